// File: rtl/bist_sequencer.sv
// BIST controller: clears the benchmark FSM, drives LFSR patterns for a
// programmed number of cycles, compacts responses in a MISR, checks signature.
module bist_sequencer #(
  parameter int unsigned NPI    = 18,
  parameter int unsigned NPO    = 19,
  parameter int unsigned CW     = 16,
  parameter int unsigned RSTCYC = 2,
  parameter logic [NPI-1:0] SEED = 18'h00001
) (
  input  logic           CK,
  input  logic           RST,
  input  logic           START,
  input  logic [CW-1:0]  NCYC,
  input  logic [NPO-1:0] GOLDEN,
  input  logic [NPO-1:0] RESP,
  output logic [NPI-1:0] PAT,
  output logic           DUT_RST,
  output logic           BUSY,
  output logic           DONE,
  output logic           PASS,
  output logic [NPO-1:0] SIG
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_CMP,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] CLR_LAST = CW'(RSTCYC - 1);

  state_e         state_q, state_d;
  logic [NPI-1:0] lfsr_q, lfsr_d;
  logic [NPO-1:0] misr_q, misr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  ncyc_q, ncyc_d;
  logic           pass_q, pass_d;
  logic           lfsr_fb;
  logic           misr_fb;

  assign lfsr_fb = lfsr_q[NPI-1] ^ lfsr_q[10];
  assign misr_fb = misr_q[NPO-1] ^ misr_q[5]
                 ^ misr_q[1] ^ misr_q[0];

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      ncyc_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      ncyc_q  <= ncyc_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    ncyc_d  = ncyc_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_CLR;
          cnt_d   = '0;
          lfsr_d  = SEED;
          misr_d  = '0;
          ncyc_d  = NCYC;
        end
      end
      S_CLR: begin
        // cnt_q doubles as the clear-hold timer before RUN
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = (ncyc_q == '0) ? S_CMP : S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        misr_d = {misr_q[NPO-2:0], misr_fb} ^ RESP;
        lfsr_d = {lfsr_q[NPI-2:0], lfsr_fb};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == ncyc_q - CW'(1)) begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        pass_d  = (misr_q == GOLDEN);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign PAT     = (state_q == S_RUN) ? lfsr_q : '0;
  assign DUT_RST = (state_q != S_RUN);
  assign BUSY    = (state_q == S_CLR) || (state_q == S_RUN)
                || (state_q == S_CMP);
  assign DONE    = (state_q == S_DONE);
  assign PASS    = pass_q;
  assign SIG     = misr_q;

endmodule
